mandelbrot_scheduler: RTL



---
 rtl/pixel_gen_pkg.sv | 18 +
 rtl/iter_color_map.sv | 39 +++
 rtl/mandelbrot_scheduler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pixel_gen_pkg.sv
// Shared types for the pixel generators: frame FSM states and colour modes.
package pixel_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DRAIN
   } state_e;

   typedef enum logic [1:0] {
      COLOR_GREY   = 2'd0,
      COLOR_LEGACY = 2'd1,
      COLOR_INSIDE = 2'd2,
      COLOR_RSVD   = 2'd3
   } color_mode_e;

endpackage

// File: rtl/iter_color_map.sv
// Maps an escape-iteration count to 8-bit RGB according to a colour mode.
module iter_color_map
   import pixel_gen_pkg::*;
#(
   parameter int ITER_W = 16
) (
   input  logic [ITER_W-1:0] iter_i,
   input  logic [ITER_W-1:0] max_iter_i,
   input  logic [1:0]        mode_i,
   output logic [7:0]        r_o,
   output logic [7:0]        g_o,
   output logic [7:0]        b_o
);

   logic [15:0] it16;

   assign it16 = 16'(iter_i);

   always_comb begin
      r_o = it16[7:0];
      g_o = it16[7:0];
      b_o = it16[7:0];
      unique case (color_mode_e'(mode_i))
         COLOR_LEGACY: b_o = it16[15:8];
         COLOR_INSIDE: begin
            if (iter_i == max_iter_i) begin
               r_o = 8'd0;
               g_o = 8'd0;
               b_o = 8'd0;
            end else begin
               r_o = 8'd0;
               b_o = ~it16[7:0];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mandelbrot_scheduler.sv
// Frame walker: dispatches pixels round-robin to NUM_CORES cores and
// collects their results back in raster order into a pixel stream.
module mandelbrot_scheduler
   import pixel_gen_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int ITER_W    = 16,
   parameter int COORD_W   = 32
) (
   input  logic                        out_stream_aclk,
   input  logic                        periph_resetn,
   input  logic                        cfg_enable,
   input  logic [X_W-1:0]              cfg_width,
   input  logic [Y_W-1:0]              cfg_height,
   input  logic [ITER_W-1:0]           cfg_max_iter,
   input  logic [COORD_W-1:0]          cfg_x_start,
   input  logic [COORD_W-1:0]          cfg_y_start,
   input  logic [COORD_W-1:0]          cfg_step,
   input  logic [1:0]                  cfg_color_mode,
   output logic [NUM_CORES-1:0]        core_start,
   output logic [COORD_W-1:0]          core_x0,
   output logic [COORD_W-1:0]          core_y0,
   output logic [ITER_W-1:0]           core_max_iter,
   input  logic [NUM_CORES-1:0]        core_done,
   input  logic [NUM_CORES*ITER_W-1:0] core_iter,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [7:0]                  pix_r,
   output logic [7:0]                  pix_g,
   output logic [7:0]                  pix_b,
   output logic                        pix_sof,
   output logic                        pix_eol,
   output logic                        pix_valid,
   input  logic                        pix_ready,
   output logic                        frame_done
);

   localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [PW-1:0] PLAST = PW'(NUM_CORES - 1);

   state_e               state_q;
   logic [X_W-1:0]       w_q, x_q;
   logic [Y_W-1:0]       h_q, y_q;
   logic [ITER_W-1:0]    mi_q, oiter_q;
   logic [COORD_W-1:0]   xs_q, st_q, xacc_q, yacc_q;
   logic [1:0]           mode_q;
   logic [PW-1:0]        dptr_q, cptr_q;
   logic [NUM_CORES-1:0] busy_q, tsof_q, teol_q;
   logic                 ov_q, osof_q, oeol_q;

   logic                 disp, coll, last_x, last_px;
   logic [ITER_W-1:0]    cur_iter;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PLAST) ? '0 : p + PW'(1);
   endfunction

   assign disp    = (state_q == ST_RUN) && !busy_q[dptr_q];
   assign last_x  = (x_q == w_q - X_W'(1));
   assign last_px = last_x && (y_q == h_q - Y_W'(1));
   assign coll    = busy_q[cptr_q] && core_done[cptr_q] &&
                    (!ov_q || pix_ready);
   assign cur_iter = core_iter[int'(cptr_q)*ITER_W +: ITER_W];

   assign core_start    = NUM_CORES'(disp) << dptr_q;
   assign core_ack      = NUM_CORES'(coll) << cptr_q;
   assign core_x0       = xacc_q;
   assign core_y0       = yacc_q;
   assign core_max_iter = mi_q;
   assign pix_valid     = ov_q;
   assign pix_sof       = osof_q;
   assign pix_eol       = oeol_q;
   assign frame_done    = (state_q == ST_DRAIN) && (busy_q == '0) && !ov_q;

   iter_color_map #(.ITER_W(ITER_W)) u_cmap (
      .iter_i     (oiter_q),
      .max_iter_i (mi_q),
      .mode_i     (mode_q),
      .r_o        (pix_r),
      .g_o        (pix_g),
      .b_o        (pix_b)
   );

   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         state_q <= ST_IDLE;
         w_q     <= '0;
         h_q     <= '0;
         mi_q    <= '0;
         xs_q    <= '0;
         st_q    <= '0;
         mode_q  <= '0;
         x_q     <= '0;
         y_q     <= '0;
         xacc_q  <= '0;
         yacc_q  <= '0;
         dptr_q  <= '0;
         cptr_q  <= '0;
         busy_q  <= '0;
         tsof_q  <= '0;
         teol_q  <= '0;
         ov_q    <= 1'b0;
         oiter_q <= '0;
         osof_q  <= 1'b0;
         oeol_q  <= 1'b0;
      end else begin
         if (coll) begin
            ov_q    <= 1'b1;
            oiter_q <= cur_iter;
            osof_q  <= tsof_q[cptr_q];
            oeol_q  <= teol_q[cptr_q];
            cptr_q  <= inc(cptr_q);
         end else if (pix_ready) begin
            ov_q <= 1'b0;
         end

         busy_q <= (busy_q | core_start) & ~core_ack;

         if (disp) begin
            tsof_q[dptr_q] <= (x_q == '0) && (y_q == '0);
            teol_q[dptr_q] <= last_x;
            dptr_q         <= inc(dptr_q);
            if (last_x) begin
               x_q    <= '0;
               xacc_q <= xs_q;
               y_q    <= y_q + Y_W'(1);
               yacc_q <= yacc_q + st_q;
            end else begin
               x_q    <= x_q + X_W'(1);
               xacc_q <= xacc_q + st_q;
            end
         end

         case (state_q)
            ST_IDLE: if (cfg_enable) state_q <= ST_LOAD;
            ST_LOAD: begin
               // Zero-sized frames are treated as one pixel wide/high.
               w_q     <= (cfg_width == '0) ? X_W'(1) : cfg_width;
               h_q     <= (cfg_height == '0) ? Y_W'(1) : cfg_height;
               mi_q    <= cfg_max_iter;
               xs_q    <= cfg_x_start;
               st_q    <= cfg_step;
               mode_q  <= cfg_color_mode;
               x_q     <= '0;
               y_q     <= '0;
               xacc_q  <= cfg_x_start;
               yacc_q  <= cfg_y_start;
               state_q <= ST_RUN;
            end
            ST_RUN: if (disp && last_px) state_q <= ST_DRAIN;
            ST_DRAIN: begin
               if (frame_done) state_q <= cfg_enable ? ST_LOAD : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
